// File: rtl/wheel_step_sequencer_if.sv
// wheel_step_sequencer_if: begin/result handshake and result buses between
// the wheel step sequencer (master) and update_wheel (slave). Signal names
// follow the sequencer's side of the link.
interface wheel_step_sequencer_if #(
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int NUM_NODES     = 4
);
  logic                                           begin_out;
  logic                                           result_in;
  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]   nodes_result_in;
  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]   velocities_result_in;

  modport master (
    output begin_out,
    input  result_in,
    input  nodes_result_in,
    input  velocities_result_in
  );

  modport slave (
    input  begin_out,
    output result_in,
    output nodes_result_in,
    output velocities_result_in
  );
endinterface

// File: rtl/wheel_step_sequencer.sv
// wheel_step_sequencer: owns the wheel node position/velocity state and runs
// STEPS_PER_FRAME update_wheel substeps per frame tick, committing each
// substep's result back into state.
// Optional per-substep watchdog: define STEP_TIMEOUT_EN.
module wheel_step_sequencer #(
  parameter int POSITION_SIZE   = 8,
  parameter int VELOCITY_SIZE   = 8,
  parameter int NUM_NODES       = 4,
  parameter int STEPS_PER_FRAME = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                         clk_in,
  input  logic                                         rst_n_in,
  input  logic                                         load_in,
  input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] init_nodes_in,
  input  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] init_velocities_in,
  input  logic                                         frame_tick_in,
  input  logic [2:0]                                   drive_in,
  wheel_step_sequencer_if.master                       wheel_if,
  output logic [2:0]                                   drive_out,
  output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes_out,
  output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] velocities_out,
  output logic                                         busy_out,
  output logic [$clog2(STEPS_PER_FRAME+1)-1:0]         step_count_out,
  output logic                                         frame_done_out,
  output logic                                         overrun_out,
  output logic                                         timeout_out
);

  localparam int              SC_W      = $clog2(STEPS_PER_FRAME + 1);
  localparam logic [SC_W-1:0] LAST_STEP = SC_W'(STEPS_PER_FRAME - 1);

  // A zero-step frame or zero-cycle watchdog has no meaning.
  if (STEPS_PER_FRAME < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("wheel_step_sequencer: STEPS_PER_FRAME and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_COMMIT
  } state_t;

  state_t                                       state_reg;
  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes_reg;
  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] velocities_reg;
  logic [2:0]                                   drive_reg;
  logic [SC_W-1:0]                              step_cnt_reg;
  logic                                         begin_reg;
  logic                                         frame_done_reg;
  logic                                         overrun_reg;
  logic                                         tmo_expire;

  // State write data: load takes the init vectors, otherwise the substep
  // result. COMMIT never coincides with load, so one mux serves both.
  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes_wr;
  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] velocities_wr;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_axis_wr
    assign nodes_wr[gi]      = load_in ? init_nodes_in[gi]      : wheel_if.nodes_result_in[gi];
    assign velocities_wr[gi] = load_in ? init_velocities_in[gi] : wheel_if.velocities_result_in[gi];
  end

`ifdef STEP_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             timeout_reg;
  logic             waiting;

  // The watchdog covers the whole responder round trip (ack and done).
  assign waiting    = (state_reg == ST_WAIT_ACK) || (state_reg == ST_WAIT_DONE);
  assign tmo_expire = waiting && (tmo_cnt_reg == TMO_LAST);

  // Watchdog counter and sticky flag; only load or reset clears the flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tmo_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else if (load_in) begin
      tmo_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else if (tmo_expire) begin
      tmo_cnt_reg <= '0;
      timeout_reg <= 1'b1;
    end else if (waiting) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
    end else begin
      tmo_cnt_reg <= '0;
    end
  end

  assign timeout_out = timeout_reg;
`else
  assign tmo_expire  = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // Substep sequencing FSM with registered pulse outputs. Load has priority
  // over everything (including the watchdog) and aborts any frame silently.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg      <= ST_IDLE;
      nodes_reg      <= '0;
      velocities_reg <= '0;
      drive_reg      <= '0;
      step_cnt_reg   <= '0;
      begin_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      begin_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      // A tick that arrives while a frame runs is dropped and reported.
      overrun_reg    <= frame_tick_in && (state_reg != ST_IDLE);

      if (load_in) begin
        nodes_reg      <= nodes_wr;
        velocities_reg <= velocities_wr;
        step_cnt_reg   <= '0;
        state_reg      <= ST_IDLE;
      end else if (tmo_expire) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (frame_tick_in) begin
              drive_reg    <= drive_in;
              step_cnt_reg <= '0;
              state_reg    <= ST_ISSUE;
            end
          end
          // Only start when the responder is idle; this also lets a run
          // left over from an aborted frame drain before the next begin.
          ST_ISSUE: begin
            if (wheel_if.result_in) begin
              begin_reg <= 1'b1;
              state_reg <= ST_WAIT_ACK;
            end
          end
          // result_in still high here is stale; wait for the accept.
          ST_WAIT_ACK: begin
            if (!wheel_if.result_in) begin
              state_reg <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: begin
            if (wheel_if.result_in) begin
              state_reg <= ST_COMMIT;
            end
          end
          ST_COMMIT: begin
            nodes_reg      <= nodes_wr;
            velocities_reg <= velocities_wr;
            step_cnt_reg   <= step_cnt_reg + SC_W'(1);
            if (step_cnt_reg == LAST_STEP) begin
              frame_done_reg <= 1'b1;
              state_reg      <= ST_IDLE;
            end else begin
              state_reg <= ST_ISSUE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign wheel_if.begin_out = begin_reg;
  assign drive_out          = drive_reg;
  assign nodes_out          = nodes_reg;
  assign velocities_out     = velocities_reg;
  assign busy_out           = (state_reg != ST_IDLE);
  assign step_count_out     = step_cnt_reg;
  assign frame_done_out     = frame_done_reg;
  assign overrun_out        = overrun_reg;

endmodule

// File: tb/tb_wheel_step_sequencer.sv
// tb_wheel_step_sequencer: table-driven and randomized frames against a
// behavioural update_wheel responder (y -= 1, every velocity += 1 per substep)
// and a frame-level model (y -= STEPS, velocity += STEPS, x unchanged).
module tb_wheel_step_sequencer;
  localparam int STEPS = 4;

  typedef logic [1:0][3:0][7:0] state_t;
  typedef logic [3:0][7:0]      axis_t;

  typedef struct {
    axis_t      x;
    axis_t      y;
    logic [7:0] v;
    int         lat;
    int         hold;
    int         inject;
    axis_t      exp_y;
    logic [7:0] exp_v;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic       frame_tick = 1'b0;
  logic [2:0] drive_in = '0;
  state_t     init_nodes = '0;
  state_t     init_vel = '0;
  logic [2:0] drive_out;
  state_t     nodes_out;
  state_t     vel_out;
  logic       busy;
  logic [2:0] step_count;
  logic       frame_done;
  logic       overrun;
  logic       timeout;

  wheel_step_sequencer_if #(.POSITION_SIZE(8), .VELOCITY_SIZE(8), .NUM_NODES(4)) wif ();

  wheel_step_sequencer #(
    .POSITION_SIZE(8), .VELOCITY_SIZE(8), .NUM_NODES(4),
    .STEPS_PER_FRAME(STEPS), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .load_in(load),
    .init_nodes_in(init_nodes), .init_velocities_in(init_vel),
    .frame_tick_in(frame_tick), .drive_in(drive_in),
    .wheel_if(wif.master),
    .drive_out(drive_out), .nodes_out(nodes_out), .velocities_out(vel_out),
    .busy_out(busy), .step_count_out(step_count), .frame_done_out(frame_done),
    .overrun_out(overrun), .timeout_out(timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural update_wheel responder ----------------
  int     resp_lat = 1;
  int     resp_hold = 0;
  bit     resp_en = 1'b1;
  bit     resp_kill = 1'b1;
  bit     resp_busy = 1'b0;
  int     hold_left = 0;
  int     low_left = 0;
  state_t pend_n = '0;
  state_t pend_v = '0;

  always @(negedge clk) begin
    if (resp_kill) begin
      resp_busy = 1'b0;
      wif.result_in = 1'b1;
      wif.nodes_result_in = '0;
      wif.velocities_result_in = '0;
    end else if (resp_busy) begin
      if (hold_left > 0) hold_left--;
      else if (low_left > 0) begin
        wif.result_in = 1'b0;
        low_left--;
      end else begin
        wif.nodes_result_in = pend_n;
        wif.velocities_result_in = pend_v;
        wif.result_in = 1'b1;
        resp_busy = 1'b0;
      end
    end else if (wif.begin_out && resp_en) begin
      resp_busy = 1'b1;
      hold_left = resp_hold;
      low_left = resp_lat;
      pend_n = nodes_out;
      for (int i = 0; i < 4; i++) pend_n[1][i] = nodes_out[1][i] - 8'd1;
      for (int a = 0; a < 2; a++)
        for (int i = 0; i < 4; i++) pend_v[a][i] = vel_out[a][i] + 8'd1;
    end
  end

  // ---------------- event monitor ----------------
  int         begin_cnt = 0, done_cnt = 0, ovr_cnt = 0, b2b_cnt = 0, sc_bad = 0;
  bit         prev_begin = 1'b0;
  logic [2:0] last_sc = '0;

  always @(negedge clk) begin
    if (wif.begin_out === 1'b1) begin
      begin_cnt++;
      if (prev_begin) b2b_cnt++;
    end
    prev_begin = (wif.begin_out === 1'b1);
    if (frame_done === 1'b1) done_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (step_count !== last_sc && step_count !== 3'(last_sc + 3'd1) && step_count !== 3'd0) sc_bad++;
    last_sc = step_count;
  end

  // ---------------- frame-level reference model ----------------
  function automatic state_t model_nodes(input state_t n);
    state_t r = n;
    for (int i = 0; i < 4; i++) r[1][i] = 8'(int'($signed(n[1][i])) - STEPS);
    return r;
  endfunction

  function automatic state_t model_vel(input state_t v);
    state_t r;
    for (int a = 0; a < 2; a++)
      for (int i = 0; i < 4; i++) r[a][i] = 8'(int'($signed(v[a][i])) + STEPS);
    return r;
  endfunction

  function automatic axis_t pk4(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic do_load(input state_t n, input state_t v);
    init_nodes = n;
    init_vel = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_and_check(input string name, input bit do_ld, input state_t n0, input state_t v0,
                               input int lat, input int hold, input int inject,
                               input state_t exp_n, input state_t exp_v);
    int b0, d0, o0, bb0, sc0;
    bit found;
    logic [2:0] drv;
    if (do_ld) do_load(n0, v0);
    drv = 3'($urandom_range(0, 7));
    drive_in = drv;
    resp_lat = lat;
    resp_hold = hold;
    b0 = begin_cnt; d0 = done_cnt; o0 = ovr_cnt; bb0 = b2b_cnt; sc0 = sc_bad;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    drive_in = ~drv;
    found = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      frame_tick = (inject > 0 && c == inject);
      @(negedge clk);
      if (frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    frame_tick = 1'b0;
    check({name, ".frame_done_seen"}, 64'(found), 64'(1));
    check({name, ".nodes"}, nodes_out, exp_n);
    check({name, ".velocities"}, vel_out, exp_v);
    check({name, ".step_count"}, 64'(step_count), 64'(STEPS));
    check({name, ".busy_at_done"}, 64'(busy), 64'(0));
    check({name, ".drive_latched"}, 64'(drive_out), 64'(drv));
    @(negedge clk);
    check({name, ".begin_pulses"}, 64'(begin_cnt - b0), 64'(STEPS));
    check({name, ".frame_done_pulses"}, 64'(done_cnt - d0), 64'(1));
    check({name, ".overrun_pulses"}, 64'(ovr_cnt - o0), 64'((inject > 0) ? 1 : 0));
    check({name, ".begin_back_to_back"}, 64'(b2b_cnt - bb0), 64'(0));
    check({name, ".step_sequence"}, 64'(sc_bad - sc0), 64'(0));
    check({name, ".timeout"}, 64'(timeout), 64'(0));
    $display("frame %s: lat=%0d hold=%0d inject=%0d nodes=%h vel=%h",
             name, lat, hold, inject, nodes_out, vel_out);
  endtask

  vec_t   vecs[4];
  state_t na, va, nb, vb;
  int     b0, d0, o0;
  bit     found;

  initial begin
    vecs[0] = '{x: pk4(-3, -2, 2, 3), y: pk4(-2, 2, 2, -2), v: 8'd0, lat: 5, hold: 0, inject: 0,
                exp_y: pk4(-6, -2, -2, -6), exp_v: 8'd4};
    vecs[1] = '{x: pk4(7, 7, 7, 7), y: pk4(-128, 127, 0, 1), v: 8'd126, lat: 1, hold: 0, inject: 0,
                exp_y: pk4(124, 123, -4, -3), exp_v: 8'd130};
    vecs[2] = '{x: pk4(-1, 0, 1, 2), y: pk4(100, -100, 5, -5), v: 8'hFE, lat: 3, hold: 3, inject: 3,
                exp_y: pk4(96, -104, 1, -9), exp_v: 8'd2};
    vecs[3] = '{x: pk4(0, 1, 2, 3), y: pk4(0, 0, 0, 0), v: 8'd127, lat: 1, hold: 1, inject: 6,
                exp_y: pk4(-4, -4, -4, -4), exp_v: 8'd131};

    // Reset: everything zero, responder idle-high, no begin.
    repeat (3) @(negedge clk);
    check("reset.nodes", nodes_out, '0);
    check("reset.velocities", vel_out, '0);
    check("reset.flags", 64'({busy, frame_done, overrun, timeout, wif.begin_out}), 64'(0));
    check("reset.drive_step", 64'({drive_out, step_count}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    resp_kill = 1'b0;
    repeat (4) @(negedge clk);
    check("reset.no_begin", 64'(begin_cnt), 64'(0));
    check("reset.idle", 64'(busy), 64'(0));

    // Table-driven frames.
    for (int k = 0; k < 4; k++) begin
      run_and_check($sformatf("vec%0d", k), 1'b1, {vecs[k].y, vecs[k].x}, {8{vecs[k].v}},
                    vecs[k].lat, vecs[k].hold, vecs[k].inject,
                    {vecs[k].exp_y, vecs[k].x}, {8{vecs[k].exp_v}});
    end

    // Load and tick together in IDLE: load wins, tick silently dropped.
    na = {pk4(9, 8, 7, 6), pk4(1, 2, 3, 4)};
    va = {8{8'd3}};
    b0 = begin_cnt; o0 = ovr_cnt;
    init_nodes = na; init_vel = va; load = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    load = 1'b0; frame_tick = 1'b0;
    check("ldtick.nodes", nodes_out, na);
    check("ldtick.busy", 64'(busy), 64'(0));
    repeat (6) @(negedge clk);
    check("ldtick.no_begin", 64'(begin_cnt - b0), 64'(0));
    check("ldtick.no_overrun", 64'(ovr_cnt - o0), 64'(0));
    $display("seq load+tick idle: nodes=%h busy=%0d", nodes_out, busy);

    // Load during WAIT_DONE (with a tick in the same cycle): abort, report
    // the dropped tick, and the next frame must let the stale run finish.
    nb = {pk4(10, 20, 30, 40), pk4(1, 2, 3, 4)};
    vb = {8{8'd5}};
    do_load(na, va);
    resp_lat = 10; resp_hold = 0;
    d0 = done_cnt;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (wif.begin_out === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort.begin_seen", 64'(found), 64'(1));
    repeat (4) @(negedge clk);
    init_nodes = nb; init_vel = vb; load = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    load = 1'b0; frame_tick = 1'b0;
    check("abort.nodes", nodes_out, nb);
    check("abort.velocities", vel_out, vb);
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.step_count", 64'(step_count), 64'(0));
    check("abort.overrun", 64'(overrun), 64'(1));
    @(negedge clk);
    check("abort.no_frame_done", 64'(done_cnt - d0), 64'(0));
    $display("seq load in WAIT_DONE: nodes=%h busy=%0d", nodes_out, busy);
    run_and_check("after_abort", 1'b0, nb, vb, 2, 0, 0, model_nodes(nb), model_vel(vb));

    // Asynchronous reset while begin_out is high.
    do_load(na, va);
    resp_lat = 6; resp_hold = 0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (wif.begin_out === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rstmid.begin_seen", 64'(found), 64'(1));
    #1 rst_n = 1'b0;
    resp_kill = 1'b1;
    #1;
    check("rstmid.begin_low", 64'(wif.begin_out), 64'(0));
    check("rstmid.busy_step", 64'({busy, step_count}), 64'(0));
    check("rstmid.nodes", nodes_out, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    resp_kill = 1'b0;
    $display("seq async reset mid-frame: busy=%0d begin=%0d", busy, wif.begin_out);

`ifdef STEP_TIMEOUT_EN
    // Responder never drops result: watchdog abandons the frame.
    resp_en = 1'b0;
    do_load(na, va);
    b0 = begin_cnt; d0 = done_cnt;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("tmo.flag", 64'(found), 64'(1));
    check("tmo.busy", 64'(busy), 64'(0));
    check("tmo.nodes", nodes_out, na);
    @(negedge clk);
    check("tmo.no_frame_done", 64'(done_cnt - d0), 64'(0));
    check("tmo.one_begin", 64'(begin_cnt - b0), 64'(1));
    check("tmo.sticky", 64'(timeout), 64'(1));
    do_load(na, va);
    check("tmo.load_clears", 64'(timeout), 64'(0));
    resp_en = 1'b1;
    $display("seq watchdog: timeout cleared by load, busy=%0d", busy);
`endif

    // Randomized frames against the frame-level model.
    for (int k = 0; k < 6; k++) begin
      state_t rn, rv;
      int inj;
      rn = {$urandom, $urandom};
      rv = {$urandom, $urandom};
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0;
      run_and_check($sformatf("rand%0d", k), 1'b1, rn, rv,
                    int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), inj,
                    model_nodes(rn), model_vel(rv));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
